instr_mem_loader: RTL and testbench

- Boot-time program loader upstream of the single-cycle processor's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words to consecutive word addresses; the processor's PC advances by 1 per instruction, so addressing is by word.
- Holds the processor in reset until the whole image has loaded and its checksum has been checked.

---
 rtl/instr_mem_loader_if.sv | 34 +++
 rtl/instr_mem_loader.sv | 203 ++++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader_if
// Description : Byte-stream input, instruction-memory write port and
//               processor-control outputs of the boot-time program loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    // Byte source / system controller side
    modport master (
        output byte_valid, byte_data, reload,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );

    // Loader side
    modport slave (
        input  byte_valid, byte_data, reload,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Assembles a big-endian byte stream into 32-bit instruction
//               words, writes them to consecutive word addresses, verifies an
//               XOR checksum and releases the processor only on success.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                 CLK,
    input  logic                 RST,
    instr_mem_loader_if.slave    bus
);

    localparam logic [2:0]  c_st_hdr0  = 3'd0;
    localparam logic [2:0]  c_st_hdr1  = 3'd1;
    localparam logic [2:0]  c_st_data  = 3'd2;
    localparam logic [2:0]  c_st_csum  = 3'd3;
    localparam logic [2:0]  c_st_done  = 3'd4;
    localparam logic [2:0]  c_st_error = 3'd5;
    localparam logic [16:0] c_depth    = 17'(DEPTH);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_run;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W:0]   r_word_cnt;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_n_hi;
    logic [7:0]        r_csum;
    logic [23:0]       r_shift;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_ready;
    logic              w_cpu_hold;
    logic              w_done;
    logic              w_err;
    logic              w_xfer;
    logic              w_restart;
    logic [15:0]       w_n;
    logic              w_n_too_big;
    logic [ADDR_W:0]   w_word_inc;
    logic              w_last_byte;
    logic              w_last_word;

    assign w_xfer      = bus.byte_valid & w_ready;
    assign w_restart   = bus.reload & ((r_state == c_st_done) | (r_state == c_st_error));
    assign w_n         = {r_n_hi, bus.byte_data};
    assign w_n_too_big = ({1'b0, w_n} > c_depth);
    assign w_word_inc  = r_word_cnt + 1'b1;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_last_word = (w_word_inc == r_count);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_st_hdr0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_hdr0: begin
                if (w_xfer) begin
                    w_next_state = c_st_hdr1;
                end
            end
            c_st_hdr1: begin
                if (w_xfer) begin
                    if (w_n_too_big) begin
                        w_next_state = c_st_error;
                    end else if (w_n == 16'd0) begin
                        w_next_state = c_st_csum;
                    end else begin
                        w_next_state = c_st_data;
                    end
                end
            end
            c_st_data: begin
                // Leaving on the final byte lets the checksum byte be taken
                // during the last write cycle, so hold release lags that write.
                if (w_xfer && w_last_byte && w_last_word) begin
                    w_next_state = c_st_csum;
                end
            end
            c_st_csum: begin
                if (w_xfer) begin
                    w_next_state = (bus.byte_data == r_csum) ? c_st_done : c_st_error;
                end
            end
            c_st_done, c_st_error: begin
                if (bus.reload) begin
                    w_next_state = c_st_hdr0;
                end
            end
            default: begin
                w_next_state = c_st_error;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ready    = 1'b0;
        w_cpu_hold = 1'b1;
        w_done     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            c_st_hdr0, c_st_hdr1, c_st_data, c_st_csum: begin
                // r_run keeps byte_ready low until the first edge after reset
                w_ready = r_run;
            end
            c_st_done: begin
                w_cpu_hold = 1'b0;
                w_done     = 1'b1;
            end
            c_st_error: begin
                w_err = 1'b1;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: header capture, word assembly, checksum, memory write
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_run      <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_word_cnt <= '0;
            r_count    <= '0;
            r_n_hi     <= 8'd0;
            r_csum     <= 8'd0;
            r_shift    <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
        end else begin
            r_run <= 1'b1;
            r_we  <= 1'b0;
            if (w_restart) begin
                r_byte_cnt <= 2'd0;
                r_word_cnt <= '0;
                r_count    <= '0;
                r_n_hi     <= 8'd0;
                r_csum     <= 8'd0;
                r_shift    <= 24'd0;
            end else if (w_xfer) begin
                case (r_state)
                    c_st_hdr0: begin
                        r_n_hi <= bus.byte_data;
                    end
                    c_st_hdr1: begin
                        if (!w_n_too_big) begin
                            r_count <= w_n[ADDR_W:0];
                        end
                    end
                    c_st_data: begin
                        r_csum     <= r_csum ^ bus.byte_data;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        r_shift    <= {r_shift[15:0], bus.byte_data};
                        if (w_last_byte) begin
                            r_we       <= 1'b1;
                            r_addr     <= r_word_cnt[ADDR_W-1:0];
                            r_wdata    <= {r_shift, bus.byte_data};
                            r_word_cnt <= w_word_inc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.cpu_hold   = w_cpu_hold;
    assign bus.done       = w_done;
    assign bus.err        = w_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Self-checking bench; images built from random words, expected
//               writes and final status derived from the image format rules.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_mem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_wr  = 0;
    bit          abort = 1'b0;
    logic [7:0]  img[$];
    logic [31:0] words[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the next expected (addr, word)
    logic prev_we   = 1'b0;
    logic prev_hold = 1'b1;
    always @(negedge CLK) begin
        if (bus.imem_we === 1'b1) begin
            n_wr++;
            if (exp_addr.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                check("wr_addr", 32'(bus.imem_addr), 32'(exp_addr.pop_front()));
                check("wr_data", bus.imem_wdata, exp_data.pop_front());
            end
            if (prev_we) check("we_back_to_back", 32'd1, 32'd0);
        end
        if (prev_hold && (bus.cpu_hold === 1'b0)) begin
            check("hold_fall_during_write", 32'(bus.imem_we), 32'd0);
        end
        prev_we   = bus.imem_we;
        prev_hold = bus.cpu_hold;
    end

    // Image = N (big-endian) | words MSB first | XOR of data bytes
    task automatic build();
        logic [7:0]  cs;
        logic [15:0] n;
        logic [31:0] w;
        logic [ADDR_W-1:0] a;
        cs = 8'd0;
        n  = 16'(words.size());
        img.delete();
        img.push_back(n[15:8]);
        img.push_back(n[7:0]);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) begin
                img.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
            a = ADDR_W'(i);
            exp_addr.push_back(a);
            exp_data.push_back(w);
        end
        img.push_back(cs);
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 1000) begin
            @(posedge CLK); #1;
            t++;
        end
        if (t >= 1000) begin
            check("ready_timeout", 32'd0, 32'd1);
            abort = 1'b1;
        end
    endtask

    task automatic send(input int stall_pct, input int nbytes);
        n_wr = 0;
        for (int i = 0; i < nbytes && !abort; i++) begin
            for (int s = 0; s < 4 && $urandom_range(99) < 32'(stall_pct); s++) begin
                bus.byte_valid = 1'b0;
                @(posedge CLK); #1;
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = img[i];
            wait_ready();
            if (!abort) begin
                @(posedge CLK); #1;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic expect_end(input bit exp_ok, input int exp_wr);
        repeat (2) @(posedge CLK);
        #1;
        check("end_done", 32'(bus.done), 32'(exp_ok));
        check("end_err", 32'(bus.err), 32'(!exp_ok));
        check("end_cpu_hold", 32'(bus.cpu_hold), 32'(!exp_ok));
        check("end_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("end_write_count", 32'(n_wr), 32'(exp_wr));
        check("end_exp_left", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        @(posedge CLK); #1;
        bus.reload = 1'b0;
        check("reload_ready", 32'(bus.byte_ready), 32'd1);
        check("reload_done", 32'(bus.done), 32'd0);
        check("reload_err", 32'(bus.err), 32'd0);
        check("reload_hold", 32'(bus.cpu_hold), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        check("rst_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        check("rel_ready_low", 32'(bus.byte_ready), 32'd0);
        @(posedge CLK); #1;
        check("rel_ready_high", 32'(bus.byte_ready), 32'd1);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        bus.reload     = 1'b0;
        #12;
        check_reset_outputs();
        release_reset();

        // Directed two-word image, source never stalls
        words.delete();
        words.push_back(32'h2008_0005);
        words.push_back(32'h2009_000A);
        build();
        send(0, img.size());
        expect_end(1'b1, 2);
        do_reload();

        // Same image, corrupted checksum byte
        build();
        img[img.size()-1] = 8'h2F;
        send(0, img.size());
        expect_end(1'b0, 2);
        do_reload();

        // Oversized header: rejected right after the second header byte
        img.delete();
        img.push_back(8'h01);
        img.push_back(8'h01);
        send(0, 2);
        check("big_n_err", 32'(bus.err), 32'd1);
        check("big_n_ready", 32'(bus.byte_ready), 32'd0);
        expect_end(1'b0, 0);
        do_reload();

        // Empty image, good then bad checksum
        words.delete();
        build();
        send(0, img.size());
        expect_end(1'b1, 0);
        do_reload();
        build();
        img[img.size()-1] = 8'h01;
        send(0, img.size());
        expect_end(1'b0, 0);
        do_reload();

        // Random images with random stalls; first one fills memory exactly
        for (int it = 0; it < 10 && !abort; it++) begin
            int  n;
            bit  good;
            n    = (it == 0) ? DEPTH : int'($urandom_range(1, 8));
            good = (it == 0) || ($urandom_range(0, 3) != 0);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            build();
            if (!good) img[img.size()-1] = img[img.size()-1] ^ 8'($urandom_range(1, 255));
            send((it % 2 == 0) ? 0 : 40, img.size());
            expect_end(good, n);
            do_reload();
        end

        // Asynchronous reset after five data bytes, then a clean reload
        words.delete();
        words.push_back(32'h2008_0005);
        words.push_back(32'h2009_000A);
        build();
        exp_addr.delete();
        exp_data.delete();
        exp_addr.push_back(ADDR_W'(0));
        exp_data.push_back(32'h2008_0005);
        send(0, 7);
        check("partial_write_count", 32'(n_wr), 32'd1);
        #3;
        RST = 1'b0;
        #1;
        check_reset_outputs();
        exp_addr.delete();
        exp_data.delete();
        release_reset();
        build();
        send(25, img.size());
        expect_end(1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
